rv32i_iterative_multiplier: RTL and testbench
=============================================

Name: rv32I_iterative_multiplier

Overview:
- Multiplier IP on the responder side of the 16x16 multiplier interface used by the execute-stage shift/multiply control path.
- Accepts two unsigned 16-bit operands under an enable/valid handshake and returns the full 32-bit unsigned product.
- Computes the product iteratively with shift-add, retiring BITS_PER_CYCLE multiplier bits per clock, and pulses valid once per operation.
- Sits beside the execute control path in instruction_execute; it is the only multiplier resource that path uses.

Parameters:
- BITS_PER_CYCLE, default 2: multiplier bits retired per iteration. Legal values are 1, 2, 4, 8. Iteration count N = 16/BITS_PER_CYCLE.

Ports:
- i_clk  input  1  clock, all state changes on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_multiplier_en  input  1  request. The initiator holds it high with stable operands until it samples valid.
- i_multiplier_operand_one  input  16  multiplicand, unsigned.
- i_multiplier_operand_two  input  16  multiplier, unsigned.
- o_multiplier_valid  output  1  one-cycle completion pulse.
- o_multiplier_result  output  32  product; valid while o_multiplier_valid=1, held afterwards.
- o_multiplier_busy  output  1  high in BUSY or DONE; debug/perf only.

Behaviour:
- Reset: i_rst wins over every other event in the same cycle.
  - State goes to IDLE.
  - o_multiplier_valid=0, o_multiplier_result=0, o_multiplier_busy=0.
  - Accumulator, operand registers and iteration counter are cleared.
- IDLE:
  - On an edge sampling en=1: capture operand_one zero-extended to 32 bits as the multiplicand register, capture operand_two as the multiplier register, clear accumulator and counter, go to BUSY.
  - On an edge sampling en=0: stay in IDLE.
- BUSY: each edge performs one iteration.
  - Add multiplicand * multiplier[BITS_PER_CYCLE-1:0] to the accumulator. Use a partial-product add of width 32, no truncation loss.
  - Shift the multiplicand left by BITS_PER_CYCLE and the multiplier right by BITS_PER_CYCLE; increment the counter.
  - On the iteration where the counter equals N-1: write the final sum to o_multiplier_result, set o_multiplier_valid=1, go to DONE.
  - Operand inputs are ignored after capture.
- DONE:
  - o_multiplier_valid falls to 0 on the next edge, so it is exactly one cycle wide.
  - Go to WAIT_LOW, or straight to IDLE if en is sampled 0 at that edge.
- WAIT_LOW:
  - Stay until en is sampled 0, then go to IDLE.
  - Reason: the initiator's en is registered and is still high on the edge after valid. Restarting there would issue a spurious second operation.
- Latency:
  - en sampled at edge E in IDLE gives o_multiplier_valid high between edges E+N and E+N+1.
  - BITS_PER_CYCLE=2 gives N=8.
  - Minimum initiation interval is N+3 cycles: valid, en falls, IDLE re-samples.
- Abort: en sampled 0 in BUSY returns to IDLE without asserting valid; o_multiplier_result keeps its previous value.
- Width rule: the product is always exact. The maximum 0xFFFF*0xFFFF = 0xFFFE0001 fits in 32 bits.
- o_multiplier_result changes only on the completing edge and on reset.
- o_multiplier_busy=1 in BUSY and DONE, 0 in IDLE and WAIT_LOW.

Test Plan:
1. BITS_PER_CYCLE=2; operands 0x1234 and 0x0002, en held until valid then dropped.
   - Required: valid high for exactly one cycle, 8 cycles after the capture edge, with result=0x00002468.
   - Required: no second valid while en lingers high.
2. Operands 0xFFFF and 0xFFFF.
   - Required: result=0xFFFE0001.
   - Then operands 0x0000 and 0xABCD: required result=0x00000000, with the same latency as before.
3. Operands change to 0x0003 and 0x0003 in the second BUSY cycle after capture of 0x0010 and 0x0010.
   - Required: result=0x00000100; the changed operands are ignored.
4. en dropped after 3 BUSY cycles of 0x00FF*0x00FF, following a prior result 0x2468.
   - Required: no valid pulse, and result stays 0x2468.
   - Then re-issue 0x00FF*0x00FF: required result=0x0000FE01.
5. i_rst asserted mid-BUSY, in the same cycle as en=1.
   - Required: next cycle busy=0, valid=0, result=0.
   - Required: a request issued after reset is released completes normally.
6. Parameter sweep BITS_PER_CYCLE=1, 4, 8 with operands 0x8001 and 0x7FFF.
   - Required: result=0x3FFFFFFF in every case.
   - Required latency: 16, 4 and 2 cycles respectively.

Source files
------------

// File: rtl/rv32i_iterative_multiplier.sv
// Iterative shift-add 16x16 -> 32 unsigned multiplier for the execute-stage multiply path.
// Latency: en sampled in IDLE at edge E -> o_multiplier_valid high for exactly one cycle after edge E+N, N = 16/BITS_PER_CYCLE.
// Backpressure: none; the initiator holds en and operands until valid, and dropping en mid-operation aborts it.
//
// Ports:
//   i_clk                     clock, all state changes on posedge
//   i_rst                     synchronous, active-high reset
//   i_multiplier_en           request, held high with stable operands until valid is sampled
//   i_multiplier_operand_one  multiplicand, unsigned 16 bits
//   i_multiplier_operand_two  multiplier, unsigned 16 bits
//   o_multiplier_valid        one-cycle completion pulse
//   o_multiplier_result       32-bit product, updated only on completion (and cleared by reset)
//   o_multiplier_busy         high in BUSY and DONE, for debug/perf counters
module rv32i_iterative_multiplier #(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_multiplier_en,
    input  logic [15:0] i_multiplier_operand_one,
    input  logic [15:0] i_multiplier_operand_two,
    output logic        o_multiplier_valid,
    output logic [31:0] o_multiplier_result,
    output logic        o_multiplier_busy
);

    localparam int N     = 16 / BITS_PER_CYCLE;
    // N never exceeds 16, so a 4-bit counter covers 0..N-1.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY     = 2'd1,
        S_DONE     = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [31:0]        mcand;
    logic [15:0]        mplier;
    logic [31:0]        acc;
    logic [CNT_W-1:0]   cnt;

    logic [31:0]        partial;
    logic [31:0]        acc_sum;
    logic               last_iter;

    logic               do_capture;
    logic               do_step;
    logic               do_finish;

    // The multiplicand register is 32 bits wide and is shifted left by
    // BITS_PER_CYCLE each step, so every partial product is already aligned
    // to its final weight. The largest product 0xFFFF*0xFFFF still fits in
    // 32 bits, so no carry out of the accumulator is ever lost.
    always_comb begin
        partial   = mcand * {{(32-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
        acc_sum   = acc + partial;
        last_iter = (cnt == CNT_W'(N - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        do_capture = 1'b0;
        do_step    = 1'b0;
        do_finish  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_multiplier_en) begin
                    do_capture = 1'b1;
                    state_nxt  = S_BUSY;
                end
            end
            S_BUSY: begin
                // Initiator withdrawing en aborts the operation; the
                // previous result stays on the output untouched.
                if (!i_multiplier_en) begin
                    state_nxt = S_IDLE;
                end else begin
                    do_step = 1'b1;
                    if (last_iter) begin
                        do_finish = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The initiator's en is registered, so it is normally still
                // high here; park in WAIT_LOW instead of re-triggering.
                state_nxt = i_multiplier_en ? S_WAIT_LOW : S_IDLE;
            end
            S_WAIT_LOW: begin
                if (!i_multiplier_en) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mcand               <= '0;
            mplier              <= '0;
            acc                 <= '0;
            cnt                 <= '0;
            o_multiplier_valid  <= 1'b0;
            o_multiplier_result <= '0;
        end else begin
            o_multiplier_valid <= do_finish;
            if (do_capture) begin
                mcand  <= {16'h0000, i_multiplier_operand_one};
                mplier <= i_multiplier_operand_two;
                acc    <= '0;
                cnt    <= '0;
            end else if (do_step) begin
                acc    <= acc_sum;
                mcand  <= mcand << BITS_PER_CYCLE;
                mplier <= mplier >> BITS_PER_CYCLE;
                cnt    <= cnt + CNT_W'(1);
            end
            if (do_finish) begin
                o_multiplier_result <= acc_sum;
            end
        end
    end

    assign o_multiplier_busy = (state == S_BUSY) || (state == S_DONE);

endmodule

// File: tb/tb_rv32i_iterative_multiplier.sv
// Bench for rv32i_iterative_multiplier: four instances (BITS_PER_CYCLE 1,2,4,8)
// share clock and reset; one instance is exercised at a time, expected products
// and completion cycles go into a queue and a monitor checks every valid pulse.
module tb_rv32i_iterative_multiplier;

    logic        clk;
    logic        rst;
    logic        en         [4];
    logic [15:0] opa        [4];
    logic [15:0] opb        [4];
    logic        valid      [4];
    logic [31:0] result     [4];
    logic        busy       [4];
    logic        prev_valid [4];
    logic [31:0] last_res   [4];

    typedef struct {
        int          inst;
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rv32i_iterative_multiplier #(
            .BITS_PER_CYCLE(1 << g)
        ) u_dut (
            .i_clk                    (clk),
            .i_rst                    (rst),
            .i_multiplier_en          (en[g]),
            .i_multiplier_operand_one (opa[g]),
            .i_multiplier_operand_two (opb[g]),
            .o_multiplier_valid       (valid[g]),
            .o_multiplier_result      (result[g]),
            .o_multiplier_busy        (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding request.
    initial begin
        for (int k = 0; k < 4; k++) prev_valid[k] = 1'b0;
    end

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (valid[k] === 1'b1) begin
                chk($sformatf("valid_width[%0d]", k), {31'd0, prev_valid[k]}, 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid[%0d]: got valid=1, expected no pulse (cycle %0d)", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("valid_inst[%0d]", k), 32'(k), 32'(e.inst));
                    chk($sformatf("result[%0d]", k), result[k], e.res);
                    chk($sformatf("latency_cycle[%0d]", k), 32'(cyc), 32'(e.due));
                end
            end
            prev_valid[k] = valid[k];
        end
    end

    // One full operation on instance k (BITS_PER_CYCLE = 1<<k). en stays high
    // for 'linger' cycles after valid; if chg > 0 the operand inputs are
    // changed to ca/cb during that BUSY cycle and must be ignored.
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input int linger, input int chg,
                          input logic [15:0] ca, input logic [15:0] cb);
        exp_t e;
        int   n;
        bit   got;
        n = 16 >> k;
        @(negedge clk);
        opa[k] = a;
        opb[k] = b;
        en[k]  = 1'b1;
        e.inst = k;
        e.res  = 32'(a) * 32'(b);
        e.due  = cyc + 1 + n;
        exp_q.push_back(e);
        last_res[k] = e.res;
        got = 1'b0;
        for (int i = 1; i <= n + 20 && !got; i++) begin
            @(negedge clk);
            if (i == 1) chk($sformatf("busy_after_capture[%0d]", k), {31'd0, busy[k]}, 32'd1);
            if (i == chg) begin
                opa[k] = ca;
                opb[k] = cb;
            end
            if (valid[k] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout[%0d]: got no valid, expected valid at cycle %0d", k, e.due);
            void'(exp_q.pop_back());
        end
        repeat (linger) @(negedge clk);
        en[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("busy_idle[%0d]", k), {31'd0, busy[k]}, 32'd0);
        chk($sformatf("result_held[%0d]", k), result[k], last_res[k]);
    endtask

    // Start an operation, then withdraw en after three BUSY cycles.
    task automatic abort_op(input int k, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        opa[k] = a;
        opb[k] = b;
        en[k]  = 1'b1;
        repeat (4) @(negedge clk);
        en[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("abort_busy[%0d]", k), {31'd0, busy[k]}, 32'd0);
        repeat (12) @(negedge clk);
        chk($sformatf("abort_result_kept[%0d]", k), result[k], last_res[k]);
    endtask

    initial begin
        int          k;
        int          r;
        logic [15:0] a;
        logic [15:0] b;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en[i]       = 1'b0;
            opa[i]      = '0;
            opb[i]      = '0;
            last_res[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_valid[%0d]", i), {31'd0, valid[i]}, 32'd0);
            chk($sformatf("reset_result[%0d]", i), result[i], 32'd0);
            chk($sformatf("reset_busy[%0d]", i), {31'd0, busy[i]}, 32'd0);
        end
        rst = 1'b0;

        // Basic product, en lingers high after valid.
        run_op(1, 16'h1234, 16'h0002, 3, 0, 16'h0, 16'h0);
        chk("t1_result", result[1], 32'h0000_2468);
        // Maximum product, then zero operand.
        run_op(1, 16'hFFFF, 16'hFFFF, 1, 0, 16'h0, 16'h0);
        chk("t2_result_max", result[1], 32'hFFFE_0001);
        run_op(1, 16'h0000, 16'hABCD, 0, 0, 16'h0, 16'h0);
        chk("t2_result_zero", result[1], 32'h0000_0000);
        // Operand change in the second BUSY cycle is ignored.
        run_op(1, 16'h0010, 16'h0010, 2, 2, 16'h0003, 16'h0003);
        chk("t3_result", result[1], 32'h0000_0100);
        // Abort keeps the previous result, re-issue completes.
        run_op(1, 16'h1234, 16'h0002, 1, 0, 16'h0, 16'h0);
        abort_op(1, 16'h00FF, 16'h00FF);
        chk("t4_abort_result", result[1], 32'h0000_2468);
        run_op(1, 16'h00FF, 16'h00FF, 1, 0, 16'h0, 16'h0);
        chk("t4_reissue_result", result[1], 32'h0000_FE01);

        // Reset mid-BUSY with en still high.
        @(negedge clk);
        opa[1] = 16'h1111;
        opb[1] = 16'h2222;
        en[1]  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_busy", {31'd0, busy[1]}, 32'd0);
        chk("t5_rst_valid", {31'd0, valid[1]}, 32'd0);
        chk("t5_rst_result", result[1], 32'd0);
        rst   = 1'b0;
        en[1] = 1'b0;
        for (int i = 0; i < 4; i++) last_res[i] = '0;
        run_op(1, 16'h0101, 16'h0003, 1, 0, 16'h0, 16'h0);

        // Parameter sweep.
        for (int i = 0; i < 4; i++) begin
            run_op(i, 16'h8001, 16'h7FFF, 1, 0, 16'h0, 16'h0);
            chk($sformatf("t6_sweep_result[%0d]", i), result[i], 32'h3FFF_FFFF);
        end

        // Randomized operations across all instances.
        for (int t = 0; t < 40; t++) begin
            k = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 7));
            a = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
            r = int'($urandom_range(0, 7));
            b = (r == 0) ? 16'h0001 : (r == 1) ? 16'hFFFF : 16'($urandom);
            run_op(k, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   16'($urandom), 16'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
